// File: rtl/mac_stream_loader.sv
// Byte-serial front/back-end for the combinational 3x3 matrix MAC.
// Assembles A then B from a valid/ready element stream, drives the MAC
// operands/opcode, captures the MAC result and offers it with valid/ready.
module mac_stream_loader #(
    parameter int unsigned DATA_WIDTH = 72,
    parameter int unsigned MAT_SIZE   = 3,
    parameter int unsigned VAR_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [VAR_WIDTH-1:0]  elem_i,
    input  logic                  elem_valid_i,
    output logic                  elem_ready_o,
    input  logic [1:0]            opcode_i,
    output logic [DATA_WIDTH-1:0] matrixA_o,
    output logic [DATA_WIDTH-1:0] matrixB_o,
    output logic [1:0]            opcode_o,
    input  logic [DATA_WIDTH-1:0] mac_result_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic                  op_err_o
);

    localparam int unsigned N_ELEM = MAT_SIZE * MAT_SIZE;
    localparam int unsigned CNT_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        EXEC,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             cnt_last;

    assign accept   = elem_valid_i && elem_ready_o;
    assign cnt_last = (cnt_q == CNT_W'(N_ELEM - 1));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode; ready/valid depend on state only
    always_comb begin
        state_d        = state_q;
        elem_ready_o   = 1'b0;
        result_valid_o = 1'b0;
        case (state_q)
            LOAD_A: begin
                elem_ready_o = 1'b1;
                if (accept && cnt_last) state_d = LOAD_B;
            end
            LOAD_B: begin
                elem_ready_o = 1'b1;
                if (accept && cnt_last) state_d = EXEC;
            end
            EXEC: begin
                state_d = DONE;
            end
            DONE: begin
                result_valid_o = 1'b1;
                if (result_ready_i) state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    // Datapath: operand shift registers, element counter, result capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            matrixA_o <= '0;
            matrixB_o <= '0;
            opcode_o  <= '0;
            result_o  <= '0;
            op_err_o  <= 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (accept) begin
                        matrixA_o <= {matrixA_o[DATA_WIDTH-VAR_WIDTH-1:0], elem_i};
                        if (cnt_q == '0) opcode_o <= opcode_i;
                        cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        matrixB_o <= {matrixB_o[DATA_WIDTH-VAR_WIDTH-1:0], elem_i};
                        cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
                    end
                end
                EXEC: begin
                    result_o <= mac_result_i;
                    op_err_o <= (opcode_o == 2'b11);
                end
                DONE: begin
                    if (result_ready_i) begin
                        op_err_o <= 1'b0;
                        cnt_q    <= '0;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_stream_loader.sv
// Self-checking bench for mac_stream_loader with a behavioural MAC model
// feeding mac_result_i and a scoreboard of expected results.
module tb_mac_stream_loader;

    localparam int unsigned DW = 72;

    typedef logic [7:0] vec9_t [9];
    typedef struct {
        logic [DW-1:0] res;
        logic          err;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [7:0]    elem;
    logic          elem_valid;
    logic          elem_ready;
    logic [1:0]    opcode_in;
    logic [DW-1:0] mat_a;
    logic [DW-1:0] mat_b;
    logic [1:0]    opcode_out;
    logic [DW-1:0] mac_result;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          result_ready;
    logic          op_err;

    int unsigned checks;
    int unsigned errors;
    exp_t        sb[$];

    mac_stream_loader #(
        .DATA_WIDTH(72),
        .MAT_SIZE  (3),
        .VAR_WIDTH (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .elem_i        (elem),
        .elem_valid_i  (elem_valid),
        .elem_ready_o  (elem_ready),
        .opcode_i      (opcode_in),
        .matrixA_o     (mat_a),
        .matrixB_o     (mat_b),
        .opcode_o      (opcode_out),
        .mac_result_i  (mac_result),
        .result_o      (result),
        .result_valid_o(result_valid),
        .result_ready_i(result_ready),
        .op_err_o      (op_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference 3x3 MAC: element [r][c] sits at bits 71-8*(3r+c) -: 8
    function automatic logic [DW-1:0] mac_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                 input logic [1:0] op);
        logic [7:0]    ea [9];
        logic [7:0]    eb [9];
        logic [7:0]    r;
        logic [DW-1:0] out;
        out = '0;
        for (int i = 0; i < 9; i++) begin
            ea[i] = a[71-8*i -: 8];
            eb[i] = b[71-8*i -: 8];
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                r = 8'h00;
                case (op)
                    2'b00: r = ea[i*3+j] + eb[i*3+j];
                    2'b01: r = ea[i*3+j] - eb[i*3+j];
                    2'b10: for (int k = 0; k < 3; k++) r = r + ea[i*3+k] * eb[k*3+j];
                    default: r = 8'h00;
                endcase
                out[71-8*(i*3+j) -: 8] = r;
            end
        end
        return out;
    endfunction

    function automatic logic [DW-1:0] pack9(input vec9_t v);
        logic [DW-1:0] p;
        p = '0;
        for (int i = 0; i < 9; i++) p[71-8*i -: 8] = v[i];
        return p;
    endfunction

    assign mac_result = mac_model(mat_a, mat_b, opcode_out);

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_elem(input logic [7:0] v, input bit gap);
        int unsigned t;
        if (gap && $urandom_range(0, 1) == 1) begin
            elem_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        elem       = v;
        elem_valid = 1'b1;
        t = 0;
        while (!elem_ready && t < 50) begin
            tick();
            t++;
        end
        if (!elem_ready) check("ready_timeout", 72'd0, 72'd1);
        tick();
        elem_valid = 1'b0;
    endtask

    task automatic run_txn(input logic [1:0] op, input vec9_t a, input vec9_t b, input bit gap);
        exp_t e;
        e.res = mac_model(pack9(a), pack9(b), op);
        e.err = (op == 2'b11);
        sb.push_back(e);
        opcode_in = op;
        for (int i = 0; i < 9; i++) send_elem(a[i], gap);
        opcode_in = ~op;
        for (int i = 0; i < 9; i++) send_elem(b[i], gap);
        check("exec_valid_low", {71'd0, result_valid}, 72'd0);
        check("exec_ready_low", {71'd0, elem_ready}, 72'd0);
    endtask

    // Pop the scoreboard when the result appears; optionally stall the consumer
    task automatic collect(input int unsigned hold, input logic [7:0] held, output logic [DW-1:0] got);
        exp_t          e;
        int unsigned   t;
        logic [DW-1:0] a_snap;
        t = 0;
        while (!result_valid && t < 10) begin
            tick();
            t++;
        end
        check("result_valid", {71'd0, result_valid}, 72'd1);
        got = result;
        if (sb.size() == 0) begin
            check("sb_empty", 72'd0, 72'd1);
        end else begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("op_err", {71'd0, op_err}, {71'd0, e.err});
        end
        a_snap = mat_a;
        if (hold > 0) begin
            elem       = held;
            elem_valid = 1'b1;
        end
        for (int i = 0; i < int'(hold); i++) begin
            tick();
            check("stall_result", result, got);
            check("stall_elem_ready", {71'd0, elem_ready}, 72'd0);
            check("stall_valid", {71'd0, result_valid}, 72'd1);
            check("stall_mat_a", mat_a, a_snap);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("post_valid", {71'd0, result_valid}, 72'd0);
        check("post_op_err", {71'd0, op_err}, 72'd0);
        check("post_ready", {71'd0, elem_ready}, 72'd1);
    endtask

    initial begin
        vec9_t         a_seq;
        vec9_t         ones;
        vec9_t         ident;
        vec9_t         zeros;
        vec9_t         f0;
        vec9_t         va;
        vec9_t         vb;
        logic [DW-1:0] got;

        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        elem         = 8'h00;
        elem_valid   = 1'b0;
        opcode_in    = 2'b00;
        result_ready = 1'b0;

        a_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        ones  = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        ident = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        zeros = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        f0    = '{8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F};

        repeat (2) tick();
        check("rst_mat_a", mat_a, '0);
        check("rst_mat_b", mat_b, '0);
        check("rst_result", result, '0);
        check("rst_opcode", {70'd0, opcode_out}, 72'd0);
        check("rst_valid", {71'd0, result_valid}, 72'd0);
        check("rst_op_err", {71'd0, op_err}, 72'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", {71'd0, elem_ready}, 72'd1);

        // Add, continuous valid
        run_txn(2'b00, a_seq, ones, 1'b0);
        collect(0, 8'h00, got);
        check("add_const", got, 72'h02030405060708090A);

        // Multiply by identity with random gaps
        run_txn(2'b10, a_seq, ident, 1'b1);
        collect(0, 8'h00, got);
        check("mul_ident_const", got, 72'h010203040506070809);

        // Subtract with wrap
        run_txn(2'b01, zeros, ones, 1'b1);
        collect(0, 8'h00, got);
        check("sub_wrap_const", got, 72'hFFFFFFFFFFFFFFFFFF);

        // Multiply overflow, then a 5-cycle consumer stall with an element waiting
        run_txn(2'b10, f0, f0, 1'b0);
        opcode_in = 2'b00;
        collect(5, 8'h55, got);
        check("mul_ovf_const", got, 72'hA3A3A3A3A3A3A3A3A3);

        // Next transaction starts with the held element as A[0][0]
        va = '{8'h55, 8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77, 8'h88, 8'h99};
        for (int i = 0; i < 9; i++) vb[i] = 8'($urandom_range(0, 255));
        run_txn(2'b00, va, vb, 1'b1);
        check("held_elem_a00", {64'd0, mat_a[71:64]}, 72'h55);
        collect(0, 8'h00, got);

        // Illegal opcode
        run_txn(2'b11, a_seq, ones, 1'b0);
        collect(0, 8'h00, got);
        check("illegal_zero", got, '0);

        // Reset mid-load, asserted between clock edges
        opcode_in = 2'b00;
        for (int i = 0; i < 5; i++) send_elem(a_seq[i], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_mat_a", mat_a, '0);
        check("mid_rst_result", result, '0);
        check("mid_rst_opcode", {70'd0, opcode_out}, 72'd0);
        check("mid_rst_valid", {71'd0, result_valid}, 72'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        run_txn(2'b00, a_seq, ones, 1'b0);
        collect(0, 8'h00, got);
        check("post_rst_add", got, 72'h02030405060708090A);

        check("sb_drained", 72'(sb.size()), 72'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
